// File: rtl/median3x3_stream.sv
// median3x3_stream: streaming 3x3 median filter with internal line buffers, valid/ready on both sides
module median3x3_stream #(
  parameter int PIX_W       = 8,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int BORDER_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eol
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  typedef logic [PIX_W-1:0] pix_t;
  state_t state_q, state_d;
  logic [CW-1:0] icol_q, icol_d, ocol_q, ocol_d, col;
  logic [RW-1:0] irow_q, irow_d, orow_q, orow_d, row;
  pix_t lb0_q [IMG_W];
  pix_t lb1_q [IMG_W];
  pix_t win_q [9];
  pix_t win_d [9];
  pix_t lo_q [3];
  pix_t lo_d [3];
  pix_t md_q [3];
  pix_t md_d [3];
  pix_t hi_q [3];
  pix_t hi_d [3];
  pix_t cen1_q, cen1_d, out_pix_q, out_pix_d, px, med;
  logic wval_q, wval_d, wbor_q, wbor_d, wsof_q, wsof_d, weol_q, weol_d;
  logic val1_q, val1_d, bor1_q, bor1_d, sof1_q, sof1_d, eol1_q, eol1_d;
  logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
  logic stall, acc, restart, step, issue, lastcol, olastcol;

  function automatic pix_t mx(input pix_t a, input pix_t b);
    return a > b ? a : b;
  endfunction
  function automatic pix_t mn(input pix_t a, input pix_t b);
    return a < b ? a : b;
  endfunction
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !rst && !stall && state_q != FLUSH;
  assign acc       = in_valid && in_ready;
  assign restart   = acc && in_sof && (icol_q != '0 || irow_q != '0);
  assign step      = acc || (state_q == FLUSH && !stall);
  assign issue     = step && !restart && state_q != FILL;
  assign col       = restart ? '0 : icol_q;
  assign row       = restart ? '0 : irow_q;
  assign px        = acc ? in_pix : '0;
  assign lastcol   = col == CW'(IMG_W - 1);
  assign olastcol  = ocol_q == CW'(IMG_W - 1);
  assign med       = med3(mx(mx(lo_q[0], lo_q[1]), lo_q[2]), med3(md_q[0], md_q[1], md_q[2]),
                          mn(mn(hi_q[0], hi_q[1]), hi_q[2]));
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

  always_comb begin
    state_d = state_q;
    icol_d  = icol_q;
    irow_d  = irow_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    if (step) begin
      icol_d = lastcol ? '0 : col + 1'b1;
      irow_d = !lastcol ? row : row == RW'(IMG_H - 1) ? '0 : row + 1'b1;
      if (issue) begin
        ocol_d = olastcol ? '0 : ocol_q + 1'b1;
        orow_d = !olastcol ? orow_q : orow_q == RW'(IMG_H - 1) ? '0 : orow_q + 1'b1;
      end
      if (restart) begin
        state_d = FILL;
        ocol_d  = '0;
        orow_d  = '0;
      end else if (state_q == FILL && row == RW'(1) && col == '0)
        state_d = RUN;
      else if (state_q == RUN && row == RW'(IMG_H - 1) && lastcol)
        state_d = FLUSH;
      else if (state_q == FLUSH && orow_q == RW'(IMG_H - 1) && olastcol) begin
        state_d = FILL;
        icol_d  = '0;
        irow_d  = '0;
      end
    end
  end

  // window shifts left; new column is {two lines ago, previous line, current pixel}
  always_comb begin
    win_d  = win_q;
    wval_d = wval_q;
    wbor_d = wbor_q;
    wsof_d = wsof_q;
    weol_d = weol_q;
    val1_d = val1_q;
    bor1_d = bor1_q;
    sof1_d = sof1_q;
    eol1_d = eol1_q;
    cen1_d = cen1_q;
    lo_d   = lo_q;
    md_d   = md_q;
    hi_d   = hi_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    if (step) begin
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2] = lb1_q[col];
      win_d[5] = lb0_q[col];
      win_d[8] = px;
    end
    if (!stall) begin
      wval_d = issue;
      wbor_d = orow_q == '0 || orow_q == RW'(IMG_H - 1) || ocol_q == '0 || olastcol;
      wsof_d = orow_q == '0 && ocol_q == '0;
      weol_d = olastcol;
      val1_d = wval_q;
      bor1_d = wbor_q;
      sof1_d = wsof_q;
      eol1_d = weol_q;
      cen1_d = win_q[4];
      for (int j = 0; j < 3; j++) begin
        lo_d[j] = mn(mn(win_q[j], win_q[3+j]), win_q[6+j]);
        md_d[j] = med3(win_q[j], win_q[3+j], win_q[6+j]);
        hi_d[j] = mx(mx(win_q[j], win_q[3+j]), win_q[6+j]);
      end
      out_valid_d = val1_q;
      if (val1_q) begin
        out_pix_d = bor1_q ? (BORDER_MODE != 0 ? '0 : cen1_q) : med;
        out_sof_d = sof1_q;
        out_eol_d = eol1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      icol_q      <= '0;
      irow_q      <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      wval_q      <= 1'b0;
      val1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      icol_q      <= icol_d;
      irow_q      <= irow_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      wval_q      <= wval_d;
      val1_q      <= val1_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // datapath is left unreset; the valid bits and border rule mask stale contents
  always_ff @(posedge clk) begin
    if (step) begin
      lb1_q[col] <= lb0_q[col];
      lb0_q[col] <= px;
    end
    win_q  <= win_d;
    wbor_q <= wbor_d;
    wsof_q <= wsof_d;
    weol_q <= weol_d;
    bor1_q <= bor1_d;
    sof1_q <= sof1_d;
    eol1_q <= eol1_d;
    cen1_q <= cen1_d;
    lo_q   <= lo_d;
    md_q   <= md_d;
    hi_q   <= hi_d;
  end
endmodule

// File: tb/tb_median3x3_stream.sv
// tb_median3x3_stream: checks both border modes side by side against a sort-based reference model
module tb_median3x3_stream;
  localparam int W = 4, H = 4, N = W * H;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [7:0] in_pix = 8'h00;
  logic in_ready0, in_ready1, out_valid0, out_valid1, sof0, sof1, eol0, eol1;
  logic [7:0] pix0, pix1;
  logic [17:0] word, prev_w;
  logic [17:0] obs[$];
  logic [17:0] expq[$];
  logic [7:0] frm[N];
  logic [5:0] pat = 6'b101001;
  logic prev_st = 1'b0;
  int n_chk = 0, n_fail = 0, rmode = 0, ph = 0, gmax = 0;
  int stall_err = 0, stall_seen = 0, irlow = 0, dual_err = 0;

  median3x3_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_pix(in_pix), .in_sof(in_sof),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pix(pix0), .out_sof(sof0), .out_eol(eol0));
  median3x3_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_pix(in_pix), .in_sof(in_sof),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pix(pix1), .out_sof(sof1), .out_eol(eol1));

  assign word = {pix0, pix1, sof0, eol0};
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_st) begin
      stall_seen++;
      if (!(out_valid0 && word == prev_w)) stall_err++;
    end
    prev_st = out_valid0 && !out_ready && !rst;
    prev_w  = word;
    if (out_valid1 !== out_valid0 || in_ready1 !== in_ready0 || sof1 !== sof0 || eol1 !== eol0) dual_err++;
    if (!rst && !in_ready0) irlow++;
    if (!rst && out_valid0 && out_ready) obs.push_back(word);
  end

  initial forever begin
    @(posedge clk);
    #1;
    ph++;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[ph % 6] : 1'($urandom_range(0, 1));
  end

  task automatic push(input logic [7:0] p, input logic s);
    int n = 0;
    logic hit = 1'b0;
    in_valid = 1'b1; in_pix = p; in_sof = s;
    while (!hit && n < 500) begin
      @(negedge clk);
      hit = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!hit) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int from, input int to);
    for (int i = from; i < to; i++) push(frm[i], i == 0);
  endtask

  // reference: border rule, else 9-value sort and take the middle
  task automatic model();
    logic [7:0] v[9];
    logic [7:0] m0, m1, t;
    int n;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          m0 = frm[r*W+c]; m1 = 8'h00;
        end else begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin v[n] = frm[(r+dr)*W+c+dc]; n++; end
          for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
              if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
          m0 = v[4]; m1 = v[4];
        end
        expq.push_back({m0, m1, r == 0 && c == 0, c == W - 1});
      end
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (obs.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (20) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rmode = 0; gmax = 0;
    foreach (frm[i]) frm[i] = 8'($urandom);
    send(0, 7);
    rst = 1'b1;
    obs.delete(); expq.delete();
    @(negedge clk);
    n_chk++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b want 0", in_ready0, in_ready1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({out_valid0, out_valid1, pix0, pix1, sof0, eol0, in_ready0} !== 21'h0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b pix=%h/%h sof=%b eol=%b rdy=%b want all 0",
                         out_valid0, pix0, pix1, sof0, eol0, in_ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", in_ready0); end
    @(posedge clk); #1;
    model();
    send(0, 5);
    repeat (10) begin @(posedge clk); #1; end
    n_chk++;
    if (obs.size() != 0) begin n_fail++; $display("FAIL fill_no_output: got %0d outputs want 0", obs.size()); end
    send(5, N);
    drain(N);
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL reset_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL reset_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_constant();
    rmode = 0; gmax = 0;
    obs.delete(); expq.delete();
    foreach (frm[i]) frm[i] = 8'h55;
    model();
    irlow = 0;
    send(0, N);
    drain(N);
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL const_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL const_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
    n_chk++;
    if (irlow != W + 1) begin n_fail++; $display("FAIL flush_ready_low: got %0d cycles want %0d", irlow, W + 1); end
  endtask

  task automatic impulse_frame();
    foreach (frm[i]) frm[i] = 8'h10;
    frm[1*W+1] = 8'hFF;
    frm[2*W+2] = 8'h00;
  endtask

  task automatic test_impulse();
    rmode = 0; gmax = 2;
    obs.delete(); expq.delete();
    impulse_frame();
    model();
    send(0, N);
    drain(N);
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL impulse_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL impulse_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_ramp();
    rmode = 0; gmax = 1;
    obs.delete(); expq.delete();
    foreach (frm[i]) frm[i] = 8'(i);
    model();
    send(0, N);
    drain(N);
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL ramp_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL ramp_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_stall();
    rmode = 1; gmax = 0;
    obs.delete(); expq.delete();
    stall_err = 0; stall_seen = 0;
    impulse_frame();
    model();
    send(0, N);
    drain(N);
    rmode = 0;
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL stall_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
    n_chk++;
    if (stall_err != 0 || stall_seen == 0) begin
      n_fail++; $display("FAIL stall_hold: %0d unstable of %0d stalled cycles, want 0 of >0", stall_err, stall_seen);
    end
  endtask

  task automatic test_sof_restart();
    int off;
    rmode = 0; gmax = 0;
    obs.delete(); expq.delete();
    foreach (frm[i]) frm[i] = 8'($urandom);
    send(0, 6);
    foreach (frm[i]) frm[i] = 8'h33;
    model();
    send(0, N);
    drain(N);
    n_chk++;
    if (obs.size() < N || obs.size() > N + 1) begin
      n_fail++; $display("FAIL restart_count: got %0d want %0d..%0d", obs.size(), N, N + 1);
    end
    off = obs.size() > N ? obs.size() - N : 0;
    foreach (expq[i]) begin
      n_chk++;
      if (i + off >= obs.size() || obs[i+off] !== expq[i]) begin
        n_fail++; $display("FAIL restart_out[%0d]: got %h want %h", i, obs[i+off], expq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f2[N];
    rmode = 2; gmax = 0;
    obs.delete(); expq.delete();
    dual_err = 0;
    foreach (f2[i]) f2[i] = 8'($urandom);
    foreach (frm[i]) frm[i] = 8'($urandom);
    model();
    send(0, N);
    frm = f2;
    model();
    send(0, N);
    drain(2 * N);
    rmode = 0;
    n_chk++;
    if (obs.size() != expq.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs.size(), expq.size());
    end
    foreach (expq[i]) begin
      n_chk++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", i, obs[i], expq[i]);
      end
    end
    n_chk++;
    if (dual_err != 0) begin n_fail++; $display("FAIL mode_handshake: %0d differing cycles want 0", dual_err); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_constant();
    test_impulse();
    test_ramp();
    test_stall();
    test_sof_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
